// File: rtl/lfsr_sync_checker.sv
// Self-synchronising PRBS checker: seeds a Fibonacci LFSR from the received
// stream, verifies it, holds lock and counts bit errors until too many accrue.
module lfsr_sync_checker #(
   parameter int                    POLY_WIDTH = 7,
   parameter logic [POLY_WIDTH-1:0] POLY       = 7'b1000001,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    LOCK_COUNT = 16,
   parameter int                    ERR_WINDOW = 64,
   parameter int                    ERR_LIMIT  = 4,
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              clear,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic                              locked,
   output logic [1:0]                        state,
   output logic                              err_valid,
   output logic [$clog2(DATA_WIDTH+1)-1:0]   err_bits,
   output logic [CNT_WIDTH-1:0]              err_count,
   output logic [CNT_WIDTH-1:0]              beat_count,
   output logic                              lock_lost
);

   localparam int DEG        = POLY_WIDTH;
   localparam int W          = DATA_WIDTH;
   localparam int EB_W       = $clog2(W + 1);
   localparam int SEED_BEATS = (DEG + W - 1) / W;
   localparam int SC_W       = $clog2(SEED_BEATS + 1);
   localparam int GC_W       = $clog2(LOCK_COUNT + 1);
   localparam int WC_W       = $clog2(ERR_WINDOW + 1);
   localparam int WE_W       = $clog2(ERR_LIMIT + 1);
   localparam int CW1        = CNT_WIDTH + 1;

   localparam logic [SC_W-1:0] SEED_BEATS_C = SC_W'(SEED_BEATS);
   localparam logic [GC_W-1:0] LOCK_COUNT_C = GC_W'(LOCK_COUNT);
   localparam logic [WC_W-1:0] ERR_WINDOW_C = WC_W'(ERR_WINDOW);
   localparam logic [WE_W-1:0] ERR_LIMIT_C  = WE_W'(ERR_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [DEG-1:0]      lfsr_reg, lfsr_next;
   logic [SC_W-1:0]     seed_cnt_reg, seed_cnt_next;
   logic [GC_W-1:0]     good_cnt_reg, good_cnt_next;
   logic [WC_W-1:0]     win_cnt_reg, win_cnt_next;
   logic [WE_W-1:0]     win_err_reg, win_err_next;
   logic                locked_reg, locked_next;
   logic                err_valid_reg, err_valid_next;
   logic [EB_W-1:0]     err_bits_reg, err_bits_next;
   logic [CNT_WIDTH-1:0] err_count_reg, err_count_next;
   logic [CNT_WIDTH-1:0] beat_count_reg, beat_count_next;
   logic                lock_lost_reg, lock_lost_next;

   logic [DEG-1:0]      pred_s, seed_s;
   logic [W-1:0]        expected, mismatch;
   logic                beat_err, drop;
   logic [EB_W-1:0]     mis_pop;
   logic [CW1-1:0]      err_sum;

   function automatic logic [EB_W-1:0] popcount(input logic [W-1:0] v);
      logic [EB_W-1:0] c;
      c = '0;
      for (int k = 0; k < W; k++) c = c + EB_W'(v[k]);
      return c;
   endfunction

   // Both the predicted and the seeded LFSR images after one beat of W serial steps
   always_comb begin
      pred_s   = lfsr_reg;
      seed_s   = lfsr_reg;
      expected = '0;
      for (int k = 0; k < W; k++) begin
         expected[k] = ^(pred_s & POLY);
         pred_s      = {expected[k], pred_s[DEG-1:1]};
         seed_s      = {in_data[k], seed_s[DEG-1:1]};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_mismatch
         assign mismatch[gi] = in_data[gi] ^ expected[gi];
      end
   endgenerate

   assign beat_err = |mismatch;
   assign mis_pop  = popcount(mismatch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         lfsr_reg       <= '0;
         seed_cnt_reg   <= '0;
         good_cnt_reg   <= '0;
         win_cnt_reg    <= '0;
         win_err_reg    <= '0;
         locked_reg     <= 1'b0;
         err_valid_reg  <= 1'b0;
         err_bits_reg   <= '0;
         err_count_reg  <= '0;
         beat_count_reg <= '0;
         lock_lost_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         lfsr_reg       <= lfsr_next;
         seed_cnt_reg   <= seed_cnt_next;
         good_cnt_reg   <= good_cnt_next;
         win_cnt_reg    <= win_cnt_next;
         win_err_reg    <= win_err_next;
         locked_reg     <= locked_next;
         err_valid_reg  <= err_valid_next;
         err_bits_reg   <= err_bits_next;
         err_count_reg  <= err_count_next;
         beat_count_reg <= beat_count_next;
         lock_lost_reg  <= lock_lost_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      lfsr_next     = lfsr_reg;
      seed_cnt_next = seed_cnt_reg;
      good_cnt_next = good_cnt_reg;
      win_cnt_next  = win_cnt_reg;
      win_err_next  = win_err_reg;
      drop          = 1'b0;
      if (!enable) begin
         state_next    = IDLE;
         lfsr_next     = '0;
         seed_cnt_next = '0;
         good_cnt_next = '0;
         win_cnt_next  = '0;
         win_err_next  = '0;
      end else begin
         case (state_reg)
            IDLE: state_next = SEED;
            SEED: if (in_valid) begin
               lfsr_next = seed_s;
               if (seed_cnt_reg + 1'b1 == SEED_BEATS_C) begin
                  seed_cnt_next = '0;
                  if (seed_s != '0) state_next = VERIFY;
               end else begin
                  seed_cnt_next = seed_cnt_reg + 1'b1;
               end
            end
            VERIFY: if (in_valid) begin
               lfsr_next = pred_s;
               if (beat_err) begin
                  state_next    = SEED;
                  good_cnt_next = '0;
                  seed_cnt_next = '0;
               end else if (good_cnt_reg + 1'b1 == LOCK_COUNT_C) begin
                  state_next    = LOCKED;
                  good_cnt_next = '0;
               end else begin
                  good_cnt_next = good_cnt_reg + 1'b1;
               end
            end
            LOCKED: if (in_valid) begin
               lfsr_next = pred_s;
               // The error limit is tested before the window wrap so a window's last beat can still drop lock
               if (win_err_reg + WE_W'(beat_err) == ERR_LIMIT_C) begin
                  drop          = 1'b1;
                  state_next    = SEED;
                  win_cnt_next  = '0;
                  win_err_next  = '0;
                  good_cnt_next = '0;
                  seed_cnt_next = '0;
               end else if (win_cnt_reg + 1'b1 == ERR_WINDOW_C) begin
                  win_cnt_next = '0;
                  win_err_next = '0;
               end else begin
                  win_cnt_next = win_cnt_reg + 1'b1;
                  win_err_next = win_err_reg + WE_W'(beat_err);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      logic active;
      active          = enable && (state_reg == LOCKED) && in_valid;
      locked_next     = (state_next == LOCKED);
      lock_lost_next  = drop;
      err_valid_next  = active && beat_err;
      err_bits_next   = (active && beat_err) ? mis_pop : err_bits_reg;
      err_sum         = {1'b0, err_count_reg} + CW1'(mis_pop);
      err_count_next  = err_count_reg;
      beat_count_next = beat_count_reg;
      if (clear) begin
         err_count_next  = '0;
         beat_count_next = '0;
      end else if (active) begin
         err_count_next  = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
         beat_count_next = (&beat_count_reg) ? beat_count_reg : beat_count_reg + 1'b1;
      end
   end

   assign state      = state_reg;
   assign locked     = locked_reg;
   assign err_valid  = err_valid_reg;
   assign err_bits   = err_bits_reg;
   assign err_count  = err_count_reg;
   assign beat_count = beat_count_reg;
   assign lock_lost  = lock_lost_reg;

endmodule
